freq_gen: RTL and testbench

FREQ_GEN -- requirements
Module: freq_gen

---
 rtl/freq_gen_pkg.sv | 22 ++
 rtl/freq_gen_sync_edge.sv | 36 +++
 rtl/freq_gen.sv | 128 ++++++++++++
 tb/tb_freq_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// Shared constants and types for the freq_gen DDS block.
// Bit-count sizing lives here so the top and the bench agree on counter range.
package freq_gen_pkg;

  localparam int ACC_W_DEF   = 28;
  localparam int TW_W_DEF    = 24;
  localparam int SYNC_STAGES = 2;

  // The bit counter must hold 0 .. tw_w+1 (the +1 is the saturation marker).
  function automatic int bit_cnt_width(input int tw_w);
    return $clog2(tw_w + 2);
  endfunction

  localparam int CNT_W_DEF = bit_cnt_width(TW_W_DEF);

  typedef enum logic [1:0] {
    LOAD_NONE   = 2'd0,
    LOAD_ACCEPT = 2'd1,
    LOAD_REJECT = 2'd2
  } load_res_e;

endpackage

// File: rtl/freq_gen_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge strobe for one asynchronous pin.
// The strobe is held off until the chain has refilled after reset, so a level held across release is not an edge.
module sync_edge
  import freq_gen_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic strobe
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   arm_q;
  logic              level;

  assign level = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= level;
      arm_q  <= {arm_q[STAGES-1:0], 1'b1};
    end
  end

  // arm_q fills one stage later than prev_q becomes valid, masking the reset-release artefact.
  assign strobe = arm_q[STAGES] & level & ~prev_q;

endmodule

// File: rtl/freq_gen.sv
// Direct digital synthesis square-wave generator with a serially loaded tuning word.
// A word is committed only when exactly TW_W bits were shifted since the previous load strobe.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int TW_W  = TW_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            ser_clk,
  input  logic            ser_data,
  input  logic            ser_load,
  output logic            sig_out,
  output logic            edge_pulse,
  output logic [TW_W-1:0] tuning_word,
  output logic            load_ok,
  output logic            load_err
);

  localparam int               CNT_W    = bit_cnt_width(TW_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TW_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TW_W + 1);

  logic                   clk_stb;
  logic                   load_stb;
  logic [SYNC_STAGES-1:0] data_q;
  logic                   data_s;

  logic [TW_W-1:0]  sr_q;
  logic [TW_W-1:0]  sr_shift;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_shift;
  load_res_e        load_res;
  logic             ok_q;
  logic             err_q;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] tw_ext;
  logic             msb_q;
  logic             edge_q;

  sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (ser_clk),
    .strobe (clk_stb)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (ser_load),
    .strobe (load_stb)
  );

  // Same depth as the ser_clk chain so data_s is the bit present when ser_clk rose.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= {data_q[SYNC_STAGES-2:0], ser_data};
    end
  end

  assign data_s = data_q[SYNC_STAGES-1];

  // A shift in the same cycle as a load lands first; the load judges the post-shift state.
  always_comb begin
    sr_shift  = sr_q;
    cnt_shift = cnt_q;
    load_res  = LOAD_NONE;
    if (clk_stb) begin
      sr_shift = {sr_q[TW_W-2:0], data_s};
      if (cnt_q != CNT_SAT) begin
        cnt_shift = cnt_q + 1'b1;
      end
    end
    if (load_stb) begin
      load_res = (cnt_shift == CNT_FULL) ? LOAD_ACCEPT : LOAD_REJECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      tuning_word <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ok_q  <= (load_res == LOAD_ACCEPT);
      err_q <= (load_res == LOAD_REJECT);
      if (load_stb) begin
        sr_q  <= '0;
        cnt_q <= '0;
      end else begin
        sr_q  <= sr_shift;
        cnt_q <= cnt_shift;
      end
      if (load_res == LOAD_ACCEPT) begin
        tuning_word <= sr_shift;
      end
    end
  end

  assign tw_ext = {{(ACC_W - TW_W){1'b0}}, tuning_word};

  // Phase is never reset by a load; a new word simply changes the step size.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      acc_q  <= '0;
      msb_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      acc_q  <= acc_q + tw_ext;
      msb_q  <= acc_q[ACC_W-1];
      edge_q <= acc_q[ACC_W-1] & ~msb_q;
    end
  end

  assign sig_out    = acc_q[ACC_W-1] & ~rst;
  assign edge_pulse = edge_q & ~rst;
  assign load_ok    = ok_q & ~rst;
  assign load_err   = err_q & ~rst;

endmodule

// File: tb/tb_freq_gen.sv
// Bench for freq_gen: serial-load scoreboard plus a cycle-level phase-accumulator reference model.
// A second, narrow instance (ACC_W=8, TW_W=4) shares the serial pins for the enable-restart timing case.
module tb_freq_gen;

  localparam int ACC_W   = 28;
  localparam int TW_W    = 24;
  localparam int S_ACC_W = 8;
  localparam int S_TW_W  = 4;

  logic clk = 1'b0;
  logic rst, enable, ser_clk, ser_data, ser_load;
  logic sig_out, edge_pulse, load_ok, load_err;
  logic [TW_W-1:0] tuning_word;
  logic s_enable, s_sig_out, s_edge_pulse, s_load_ok, s_load_err;
  logic [S_TW_W-1:0] s_tuning_word;

  int checks   = 0;
  int failures = 0;

  // Stimulus-side model: bits shifted since the last load and the committed word.
  logic [TW_W:0]   exp_q[$];
  bit              bits_q[$];
  logic [TW_W-1:0] tw_exp = '0;

  // Monitor-side model of the accumulator and output history.
  logic [ACC_W-1:0] acc_m = '0;
  logic [TW_W-1:0]  tw_m = '0;
  logic s1 = 1'b0, s2 = 1'b0, ep_m = 1'b0, rst_prev = 1'b1, en_prev = 1'b0;
  int s_ok_cnt = 0, s_err_cnt = 0;

  freq_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ser_clk     (ser_clk),
    .ser_data    (ser_data),
    .ser_load    (ser_load),
    .sig_out     (sig_out),
    .edge_pulse  (edge_pulse),
    .tuning_word (tuning_word),
    .load_ok     (load_ok),
    .load_err    (load_err)
  );

  freq_gen #(.ACC_W(S_ACC_W), .TW_W(S_TW_W)) u_small (
    .clk         (clk),
    .rst         (rst),
    .enable      (s_enable),
    .ser_clk     (ser_clk),
    .ser_data    (ser_data),
    .ser_load    (ser_load),
    .sig_out     (s_sig_out),
    .edge_pulse  (s_edge_pulse),
    .tuning_word (s_tuning_word),
    .load_ok     (s_load_ok),
    .load_err    (s_load_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_load();
    logic [TW_W-1:0] w;
    w = '0;
    if (bits_q.size() == TW_W) begin
      foreach (bits_q[i]) w = {w[TW_W-2:0], bits_q[i]};
      tw_exp = w;
      exp_q.push_back({1'b1, w});
    end else begin
      exp_q.push_back({1'b0, tw_exp});
    end
    bits_q.delete();
  endtask

  task automatic send_bit(input logic b, input bit with_load);
    ser_data = b;
    tick($urandom_range(1, 3));
    bits_q.push_back(b);
    if (with_load) model_load();
    ser_clk = 1'b1;
    if (with_load) ser_load = 1'b1;
    tick($urandom_range(3, 6));
    ser_clk  = 1'b0;
    ser_load = 1'b0;
    tick($urandom_range(3, 6));
  endtask

  task automatic shift_bits(input int n, input logic [63:0] v, input bit load_last);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], load_last && (i == 0));
  endtask

  task automatic do_load();
    model_load();
    ser_load = 1'b1;
    tick($urandom_range(3, 5));
    ser_load = 1'b0;
    tick($urandom_range(5, 7));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL load_response_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_and_check(input string name);
    wait_drain();
    check(name, tuning_word, tw_exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [TW_W:0] e;
    if (rst_prev) begin
      acc_m = '0;
      tw_m  = '0;
      s1    = 1'b0;
      s2    = 1'b0;
      ep_m  = 1'b0;
    end else begin
      ep_m  = en_prev && s1 && !s2;
      acc_m = en_prev ? acc_m + ACC_W'(tw_m) : '0;
      s2    = s1;
      s1    = acc_m[ACC_W-1];
    end
    check("sig_out", sig_out, rst ? 1'b0 : s1);
    check("edge_pulse", edge_pulse, rst ? 1'b0 : ep_m);
    if (load_ok || load_err) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL load_pulse_unexpected ok=%0b err=%0b required=none t=%0t",
                 load_ok, load_err, $time);
      end else begin
        e = exp_q.pop_front();
        check("load_kind", {load_ok, load_err}, e[TW_W] ? 2'b10 : 2'b01);
        check("load_word", tuning_word, e[TW_W-1:0]);
        if (e[TW_W]) tw_m = e[TW_W-1:0];
      end
    end
    check("tuning_word", tuning_word, tw_m);
    if (s_load_ok) s_ok_cnt++;
    if (s_load_err) s_err_cnt++;
    rst_prev = rst;
    en_prev  = enable;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] v;
    int n, cyc, high, ok0, err0;

    rst = 1'b1; enable = 1'b0; s_enable = 1'b0;
    ser_clk = 1'b0; ser_data = 1'b0; ser_load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_sig_out", sig_out, 1'b0);
    check("reset_edge_pulse", edge_pulse, 1'b0);
    check("reset_load_ok", load_ok, 1'b0);
    check("reset_load_err", load_err, 1'b0);
    check("reset_tuning_word", tuning_word, '0);
    check("reset_small_tuning_word", s_tuning_word, '0);
    tick(1);
    rst = 1'b0;
    tick(6);
    enable = 1'b1;

    // 0x100000 gives a 256-cycle period at ACC_W=28
    shift_bits(24, 64'h100000, 1'b0);
    do_load();
    load_and_check("tw_0x100000");
    n = 0;
    while (!edge_pulse && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_edge_seen", edge_pulse, 1'b1);
    cyc = 0;
    high = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      high += int'(sig_out);
    end while (!edge_pulse && cyc < 600);
    check("period_cycles", cyc, 256);
    check("high_cycles", high, 128);
    tick(1);

    // short, recovery, over-long and empty loads
    shift_bits(23, {$urandom, $urandom}, 1'b0);
    do_load();
    load_and_check("tw_after_23_bits");
    shift_bits(24, {$urandom, $urandom}, 1'b0);
    do_load();
    load_and_check("tw_after_recovery_24");
    shift_bits(30, {$urandom, $urandom}, 1'b0);
    do_load();
    load_and_check("tw_after_30_bits");
    do_load();
    load_and_check("tw_after_empty_load");

    // last bit and load strobe in the same cycle
    shift_bits(24, 64'h5A5A5B, 1'b1);
    load_and_check("tw_same_cycle_load");

    // reset mid-shift with both strobe pins held high across release
    shift_bits(12, {$urandom, $urandom}, 1'b0);
    rst = 1'b1;
    bits_q.delete();
    tw_exp = '0;
    tick(1);
    ser_clk = 1'b1; ser_load = 1'b1; ser_data = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(8);
    check("tw_after_reset", tuning_word, '0);
    ser_clk = 1'b0; ser_load = 1'b0;
    tick(6);
    shift_bits(24, {$urandom, $urandom}, 1'b0);
    do_load();
    load_and_check("tw_post_reset_word");

    // narrow instance: word 1, run, disable, restart timing
    ok0 = s_ok_cnt;
    err0 = s_err_cnt;
    shift_bits(S_TW_W, 64'h1, 1'b0);
    do_load();
    wait_drain();
    check("small_load_ok_count", s_ok_cnt - ok0, 1);
    check("small_load_err_count", s_err_cnt - err0, 0);
    check("small_tuning_word", s_tuning_word, 4'h1);
    s_enable = 1'b1;
    tick(200);
    check("small_sig_high_at_200", s_sig_out, 1'b1);
    s_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("small_disabled_sig", s_sig_out, 1'b0);
      check("small_disabled_edge", s_edge_pulse, 1'b0);
    end
    s_enable = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!s_edge_pulse && cyc < 400);
    check("small_first_edge_cycles", cyc, (1 << (S_ACC_W - 1)) + 1);
    s_enable = 1'b0;
    tick(1);

    // randomized loads with enable toggling, checked by the monitor model
    for (int t = 0; t < 14; t++) begin
      enable = ($urandom_range(0, 3) != 0);
      n = ($urandom_range(0, 9) < 7) ? TW_W : int'($urandom_range(0, 30));
      v = {$urandom, $urandom};
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        shift_bits(n, v, 1'b1);
      end else begin
        shift_bits(n, v, 1'b0);
        do_load();
      end
      load_and_check("tw_random_load");
      tick($urandom_range(0, 300));
    end

    wait_drain();
    tick(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
